// File: rtl/debug_data_receiver_pkg.sv
// Shared constants and types for the debug serial frame receiver.
// The optional frame-error flag is enabled by defining DEBUG_RX_FRAME_ERR_EN.
package debug_data_receiver_pkg;

    // Payload width of one debug serial frame.
    localparam int DEBUG_DATA_W = 40;

    // Bit counter width: must be able to hold the value DEBUG_DATA_W itself.
    localparam int DEBUG_CNT_W  = $clog2(DEBUG_DATA_W + 1);

    // Receiver FSM: waiting for a frame marker, or shifting payload bits.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/debug_data_receiver_ff2sync.sv
// Two-flop synchronizer for a single asynchronous bit into the clk domain.
// Both flops clear to 0 on reset.
module FF2SyncP (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule

// File: rtl/debug_data_receiver.sv
// Debug serial frame receiver: oversamples sclk/sframe/sin in the clk domain,
// assembles MSB-first words and presents them on a one-deep valid/ready buffer.
// Optional sticky frame_err output is built when DEBUG_RX_FRAME_ERR_EN is defined.
//
// Handshake: out_valid is held with out_data stable until a clk edge where
// out_valid && out_ready; that edge consumes the word. A word that completes
// while the buffer is full and not being consumed is dropped and sets overrun.
module debug_data_receiver
    import debug_data_receiver_pkg::*;
#(
    parameter int DATA_W = DEBUG_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              sframe,
    input  logic              sin,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
`ifdef DEBUG_RX_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output rx_state_e         dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              w_sclk_s;
    logic              w_sframe_s;
    logic              w_sin_s;
    logic              w_sample;

    logic              r_sclk_d;
    rx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_done;

    rx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_done_nxt;

    FF2SyncP u_sync_sclk (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (sclk),
        .q     (w_sclk_s)
    );

    FF2SyncP u_sync_sframe (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (sframe),
        .q     (w_sframe_s)
    );

    FF2SyncP u_sync_sin (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (sin),
        .q     (w_sin_s)
    );

    // Delayed synchronized sclk for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
        end
    end

    // Sender changes data on falling sclk, so the rising edge is the safe sample point.
    assign w_sample = w_sclk_s & ~r_sclk_d;

    // FSM, bit counter, shift register and word-complete pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: a marked sample always (re)starts a frame; unmarked samples shift only in SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        if (w_sample) begin
            if (w_sframe_s) begin
                w_shift_nxt = {{(DATA_W-1){1'b0}}, w_sin_s};
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                w_shift_nxt = {r_shift[DATA_W-2:0], w_sin_s};
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            // Counter parks at DATA_W in IDLE until the next marker, so it never wraps.
            if ((w_state_nxt == ST_SHIFT) && (w_cnt_nxt == CNT_W'(DATA_W))) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    // One-deep output buffer: load on completion if free or draining, else flag overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (r_done) begin
            if (!out_valid || out_ready) begin
                out_data  <= r_shift;
                out_valid <= 1'b1;
            end else begin
                overrun   <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEBUG_RX_FRAME_ERR_EN
    logic w_restart;

    // A marker arriving mid-frame means the previous frame was cut short.
    assign w_restart = w_sample & w_sframe_s & (r_state == ST_SHIFT);

    // Sticky frame error, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (w_restart) begin
            frame_err <= 1'b1;
        end
    end
`endif

    assign dbg_state = r_state;

endmodule

// File: tb/tb_debug_data_receiver.sv
// Directed bench for debug_data_receiver: clk runs at 8x sclk, inputs change
// 2 ns after a clk rising edge, outputs are observed the same way.
module tb_debug_data_receiver;
    import debug_data_receiver_pkg::*;

    localparam int W = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         sclk;
    logic         sframe;
    logic         sin;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
`ifdef DEBUG_RX_FRAME_ERR_EN
    logic         frame_err;
`endif
    rx_state_e    dbg_state;

    debug_data_receiver #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .sframe    (sframe),
        .sin       (sin),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
`ifdef DEBUG_RX_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Record every accepted word; sampled mid-cycle so the next rising edge consumes it.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_got(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input logic fr);
        sclk   = 1'b0;
        sin    = b;
        sframe = fr;
        wait_clk(4);
        sclk   = 1'b1;
        wait_clk(4);
    endtask

    // Full frame. With lat_chk, the last rising sclk needs 2 clk through the
    // synchronizer to become the sample event, then out_valid follows 2 clk later.
    task automatic send_word(input logic [W-1:0] w, input bit lat_chk);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0 && lat_chk) begin
                sclk   = 1'b0;
                sin    = w[i];
                sframe = 1'b0;
                wait_clk(4);
                sclk   = 1'b1;
                wait_clk(3);
                check("lat_before", 64'(out_valid), 64'd0);
                wait_clk(1);
                check("lat_at", 64'(out_valid), 64'd1);
                wait_clk(0);
            end else begin
                send_bit(w[i], (i == W - 1));
            end
        end
    endtask

    task automatic send_partial(input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[W-1-i], (i == 0));
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n   = 1'b0;
        sclk      = 1'b0;
        sframe    = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;
        wait_clk(3);

        // Reset state
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovr",   64'(overrun),   64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
`ifdef DEBUG_RX_FRAME_ERR_EN
        check("rst_ferr",  64'(frame_err), 64'd0);
`endif
        reset_n = 1'b1;
        wait_clk(2);

        // Single frame, latency and data
        send_word(40'hA999999991, 1'b1);
        check("t1_data", 64'(out_data), 64'hA999999991);
        check("t1_ovr",  64'(overrun),  64'd0);
        exp_q.push_back(40'hA999999991);
        out_ready = 1'b1;
        wait_clk(1);
        check("t1_valid_clr", 64'(out_valid), 64'd0);
        check_got("t1");

        // Back-to-back frames with consumer ready
        send_word(40'hA999999981, 1'b0);
        send_word(40'hE999999993, 1'b1);
        wait_clk(2);
        exp_q.push_back(40'hA999999981);
        exp_q.push_back(40'hE999999993);
        check_got("t2");
        check("t2_ovr", 64'(overrun), 64'd0);

        // Overrun: consumer stalled across two frames
        out_ready = 1'b0;
        send_word(40'h0000000001, 1'b1);
        send_word(40'hFFFFFFFFFF, 1'b0);
        wait_clk(6);
        check("t3_data",  64'(out_data),  64'h0000000001);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_ovr",   64'(overrun),   64'd1);
        out_ready = 1'b1;
        wait_clk(1);
        check("t3_valid_clr", 64'(out_valid), 64'd0);
        wait_clk(3);
        check("t3_valid_stay", 64'(out_valid), 64'd0);
        exp_q.push_back(40'h0000000001);
        check_got("t3");
`ifdef DEBUG_RX_FRAME_ERR_EN
        check("t3_ferr", 64'(frame_err), 64'd0);
`endif

        // Frame restarted after 17 bits
        send_partial(40'hCAFEBABE12, 17);
        send_word(40'h123456789A, 1'b1);
        wait_clk(2);
        exp_q.push_back(40'h123456789A);
        check_got("t4");
        check("t4_ovr_sticky", 64'(overrun),   64'd1);
        check("t4_state",      64'(dbg_state), 64'(ST_IDLE));
`ifdef DEBUG_RX_FRAME_ERR_EN
        check("t4_ferr", 64'(frame_err), 64'd1);
`endif

        // Reset mid-frame after 20 bits
        send_partial(40'h0F0F0F0F0F, 20);
        reset_n = 1'b0;
        wait_clk(2);
        check("t5_rst_data",  64'(out_data),  64'd0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_ovr",   64'(overrun),   64'd0);
        check("t5_rst_state", 64'(dbg_state), 64'(ST_IDLE));
`ifdef DEBUG_RX_FRAME_ERR_EN
        check("t5_rst_ferr",  64'(frame_err), 64'd0);
`endif
        reset_n = 1'b1;
        wait_clk(2);
        send_idle(20);
        check("t5_no_out", 64'(out_valid), 64'd0);
        send_word(40'h5A5A5A5A5A, 1'b1);
        wait_clk(2);
        exp_q.push_back(40'h5A5A5A5A5A);
        check_got("t5");
        check("t5_ovr", 64'(overrun), 64'd0);

        // Idle gaps with toggling sin between frames
        send_word(40'h0123456789, 1'b1);
        send_idle(6);
        check("t6_gap1", 64'(out_valid), 64'd0);
        send_word(40'h8000000001, 1'b0);
        send_idle(6);
        check("t6_gap2", 64'(out_valid), 64'd0);
        send_word(40'h7FFFFFFFFE, 1'b0);
        send_idle(6);
        check("t6_gap3", 64'(out_valid), 64'd0);
        exp_q.push_back(40'h0123456789);
        exp_q.push_back(40'h8000000001);
        exp_q.push_back(40'h7FFFFFFFFE);
        check_got("t6");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
